fft8_sequencer: RTL

- Controller and scheduler for a single shared radix-2 butterfly datapath.
- Computes an 8-point complex DIT FFT in place over an internal 8-entry sample buffer: 3 stages x 4 butterfly ops, one op per clock.
- Streams samples in and results out over valid/ready handshakes.
- Sits between the sample source and the downstream spectrum consumer.

---
 rtl/fft8_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fft8_sequencer.sv
// 8-point radix-2 DIT FFT sequencer over one shared butterfly; 13 cycles last-in to first-out, 12 ops then registered output.
// Valid/ready both sides, no input outside LOAD, output holds while out_ready=0; FFT8_STAGE_SCALE_EN halves every butterfly result.
module fft8_sequencer #(
  parameter int W       = 16,
  parameter int TW_FRAC = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         busy
);

  localparam int TWW    = TW_FRAC + 2;
  localparam int PW     = W + TWW + 1;
  localparam int TW_ONE = 1 << TW_FRAC;
  localparam int TW_C45 = int'(0.7071067811865476 * real'(TW_ONE));

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cpx_t;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] op;
  cpx_t       mem [8];

  logic [1:0] stg, k, tw_idx;
  logic [2:0] a_idx, b_idx;

  assign stg = op[3:2];
  assign k   = op[1:0];

  // Butterfly pair and twiddle index for stage stg, op k.
  always_comb begin
    a_idx  = '0;
    b_idx  = '0;
    tw_idx = '0;
    case (stg)
      2'd0: begin
        a_idx  = {k, 1'b0};
        b_idx  = {k, 1'b1};
        tw_idx = 2'd0;
      end
      2'd1: begin
        a_idx  = {k[1], 1'b0, k[0]};
        b_idx  = {k[1], 1'b1, k[0]};
        tw_idx = {k[0], 1'b0};
      end
      default: begin
        a_idx  = {1'b0, k};
        b_idx  = {1'b1, k};
        tw_idx = k;
      end
    endcase
  end

  logic signed [TWW-1:0] wr, wi;

  always_comb begin
    wr = '0;
    wi = '0;
    case (tw_idx)
      2'd0: begin wr = TWW'(TW_ONE);  wi = '0;              end
      2'd1: begin wr = TWW'(TW_C45);  wi = TWW'(-TW_C45);   end
      2'd2: begin wr = '0;            wi = TWW'(-TW_ONE);   end
      default: begin wr = TWW'(-TW_C45); wi = TWW'(-TW_C45); end
    endcase
  end

  cpx_t av, bv, ya, yb;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [W-1:0]  p_re, p_im;

  assign av = mem[a_idx];
  assign bv = mem[b_idx];

  assign prod_re = PW'(bv.re) * PW'(wr) - PW'(bv.im) * PW'(wi);
  assign prod_im = PW'(bv.re) * PW'(wi) + PW'(bv.im) * PW'(wr);
  assign p_re    = W'(prod_re >>> TW_FRAC);
  assign p_im    = W'(prod_im >>> TW_FRAC);

`ifdef FFT8_STAGE_SCALE_EN
  logic signed [W:0] sa_re, sa_im, sb_re, sb_im;

  // One guard bit so the halved result never overflows.
  assign sa_re = (W+1)'(av.re) + (W+1)'(p_re);
  assign sa_im = (W+1)'(av.im) + (W+1)'(p_im);
  assign sb_re = (W+1)'(av.re) - (W+1)'(p_re);
  assign sb_im = (W+1)'(av.im) - (W+1)'(p_im);
  assign ya    = {W'(sa_re >>> 1), W'(sa_im >>> 1)};
  assign yb    = {W'(sb_re >>> 1), W'(sb_im >>> 1)};
`else
  assign ya = {av.re + p_re, av.im + p_im};
  assign yb = {av.re - p_re, av.im - p_im};
`endif

  // Sample buffer carries no reset; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready)
      mem[{cnt[0], cnt[1], cnt[2]}] <= {in_re, in_im};
    if (state == COMPUTE) begin
      mem[a_idx] <= ya;
      mem[b_idx] <= yb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= '0;
      op        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              op       <= '0;
            end
          end
        end
        COMPUTE: begin
          op <= op + 4'd1;
          if (op == 4'd11) begin
            state <= UNLOAD;
            cnt   <= '0;
          end
        end
        UNLOAD: begin
          if (!out_valid) begin
            out_re    <= mem[cnt].re;
            out_im    <= mem[cnt].im;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (cnt == 3'd7) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= LOAD;
              cnt       <= '0;
            end else begin
              cnt    <= cnt + 3'd1;
              out_re <= mem[cnt + 3'd1].re;
              out_im <= mem[cnt + 3'd1].im;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
